// File: rtl/jtcps1_linebuf_pkg.sv
// Shared constants for the CPS1 line-write path (colour mixer, line buffer, frame buffer).
package jtcps1_linebuf_pkg;

    localparam int unsigned LBUF_AW = 9;
    localparam int unsigned LBUF_DW = 12;
    localparam int unsigned CNT_W   = 8;

    localparam logic [LBUF_AW-1:0] LBUF_LAST  = 9'd383;
    localparam logic [LBUF_DW-1:0] LBUF_BLANK = 12'hFFF;

    // Saturating increment for event counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/jtcps1_lbuf_bank.sv
// One line-buffer bank: simple dual-port RAM, one write port, one registered read port.
module jtcps1_lbuf_bank #(
    parameter int unsigned     AW      = 9,
    parameter int unsigned     DW      = 12,
    parameter logic [DW-1:0]   RST_VAL = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a clear at the read address returns the old pixel
    always_ff @(posedge clk) begin
        if (!rst)       rd_data <= RST_VAL;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jtcps1_linebuf.sv
// Ping-pong line buffer between the colour mixer and video output.
// JTCPS1_LBUF_CLR_EN: read side writes BLANK behind the scan so banks return blank.
module jtcps1_linebuf
    import jtcps1_linebuf_pkg::*;
#(
    parameter int unsigned   AW    = LBUF_AW,
    parameter int unsigned   DW    = LBUF_DW,
    parameter logic [AW-1:0] LAST  = LBUF_LAST,
    parameter logic [DW-1:0] BLANK = LBUF_BLANK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen8,
    input  logic             line_start,
    input  logic [DW-1:0]    line_data,
    input  logic [AW-1:0]    line_addr,
    input  logic             line_wr,
    output logic             line_wr_ok,
    input  logic [AW-1:0]    hdump,
    output logic [DW-1:0]    pix,
    output logic             late,
    output logic [CNT_W-1:0] late_cnt
);

    logic          wr_bank;
    logic          rd_sel;
    logic          init_done;
    logic          swap_c;
    logic          wr_acc_c;
    logic [1:0]    we_c;
    logic [AW-1:0] waddr_c [2];
    logic [DW-1:0] wdata_c [2];
    logic [DW-1:0] q       [2];

    assign swap_c   = line_start && cen8;
    assign wr_acc_c = line_wr && line_wr_ok;

    // Route writer to the write bank; the read bank gets the clear (if built in)
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we_c[b]    = 1'b0;
            waddr_c[b] = line_addr;
            wdata_c[b] = line_data;
            if (wr_bank == 1'(b)) begin
                we_c[b] = wr_acc_c;
            end else begin
`ifdef JTCPS1_LBUF_CLR_EN
                we_c[b]    = cen8;
                waddr_c[b] = hdump;
                wdata_c[b] = BLANK;
`else
                we_c[b]    = 1'b0;
`endif
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        jtcps1_lbuf_bank #(
            .AW      (AW),
            .DW      (DW),
            .RST_VAL (BLANK)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (we_c[g]),
            .wr_addr (waddr_c[g]),
            .wr_data (wdata_c[g]),
            .rd_en   (cen8),
            .rd_addr (hdump),
            .rd_data (q[g])
        );
    end

    // Bank roles, write-enable window and lateness tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank    <= 1'b1;
            rd_sel     <= 1'b0;
            init_done  <= 1'b0;
            line_wr_ok <= 1'b0;
            late       <= 1'b0;
            late_cnt   <= '0;
        end else begin
            init_done <= 1'b1;
            late      <= 1'b0;
            if (cen8) rd_sel <= ~wr_bank;
            if (swap_c) begin
                wr_bank    <= ~wr_bank;
                line_wr_ok <= 1'b1;
                if (line_wr_ok) begin
                    late     <= 1'b1;
                    late_cnt <= sat_inc(late_cnt);
                end
            end else if (wr_acc_c && line_addr == LAST) begin
                line_wr_ok <= 1'b0;
            end else if (!init_done) begin
                line_wr_ok <= 1'b1;
            end
        end
    end

    // rd_sel follows the bank that fed the last read, so pix is a bank output register
    assign pix = rd_sel ? q[1] : q[0];

endmodule

// File: tb/tb_jtcps1_linebuf.sv
// Directed bench for jtcps1_linebuf; cen8 is high every fourth clk.
module tb_jtcps1_linebuf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen8;
    logic        line_start = 1'b0;
    logic [11:0] line_data = '0;
    logic [8:0]  line_addr = '0;
    logic        line_wr = 1'b0;
    logic        line_wr_ok;
    logic [8:0]  hdump = '0;
    logic [11:0] pix;
    logic        late;
    logic [7:0]  late_cnt;

    logic [1:0]  ph = '0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp200;
    logic [31:0] exp383;

    jtcps1_linebuf dut (
        .clk        (clk),
        .rst        (rst),
        .cen8       (cen8),
        .line_start (line_start),
        .line_data  (line_data),
        .line_addr  (line_addr),
        .line_wr    (line_wr),
        .line_wr_ok (line_wr_ok),
        .hdump      (hdump),
        .pix        (pix),
        .late       (late),
        .late_cnt   (late_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ph + 2'd1;
    assign cen8 = (ph == 2'd3);

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Park on the negedge just before a cen8 edge
    task automatic to_cen();
        @(negedge clk);
        for (int i = 0; i < 4 && ph != 2'd3; i++) @(negedge clk);
    endtask

    task automatic wr_px(input logic [8:0] a, input logic [11:0] d);
        @(negedge clk);
        line_wr = 1'b1; line_addr = a; line_data = d;
        @(posedge clk); #1;
        line_wr = 1'b0;
    endtask

    task automatic swap();
        to_cen();
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic rd(input logic [8:0] h, input logic [11:0] e, input string tag);
        to_cen();
        hdump = h;
        @(posedge clk); #1;
        check(tag, 32'(pix), 32'(e));
    endtask

    initial begin
        // Reset
        repeat (6) @(posedge clk);
        #1;
        check("rst_pix", 32'(pix), 32'hFFF);
        check("rst_wr_ok", 32'(line_wr_ok), 32'd0);
        check("rst_late", 32'(late), 32'd0);
        check("rst_late_cnt", 32'(late_cnt), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rel_wr_ok", 32'(line_wr_ok), 32'd1);

        // Full line, value = column
        for (int a = 0; a < 383; a++) wr_px(9'(a), 12'(a));
        check("pre_last_wr_ok", 32'(line_wr_ok), 32'd1);
        wr_px(9'd383, 12'd383);
        check("post_last_wr_ok", 32'(line_wr_ok), 32'd0);
        wr_px(9'd7, 12'h123);
        check("dropped_wr_ok", 32'(line_wr_ok), 32'd0);
        swap();
        check("full_late", 32'(late), 32'd0);
        check("full_wr_ok", 32'(line_wr_ok), 32'd1);
        check("full_late_cnt", 32'(late_cnt), 32'd0);
        rd(9'd5, 12'h005, "rd5");
        @(negedge clk); hdump = 9'd7;
        @(posedge clk); #1;
        check("pix_hold", 32'(pix), 32'h005);
        rd(9'd7, 12'h007, "rd7_drop");
        rd(9'd383, 12'h17F, "rd383");
        rd(9'd0, 12'h000, "rd0");

        // Short line: late
        for (int a = 0; a < 100; a++) wr_px(9'(a), 12'h200 + 12'(a));
        swap();
        check("short_late", 32'(late), 32'd1);
        check("short_late_cnt", 32'(late_cnt), 32'd1);
        @(posedge clk); #1;
        check("late_one_cycle", 32'(late), 32'd0);
        rd(9'd0, 12'h200, "short0");
        rd(9'd50, 12'h232, "short50");
        rd(9'd99, 12'h263, "short99");

        // Write in the swap cycle
        to_cen();
        line_start = 1'b1; line_wr = 1'b1; line_addr = 9'd383; line_data = 12'h3C3;
        @(posedge clk); #1;
        line_start = 1'b0; line_wr = 1'b0;
        check("sw_wr_ok", 32'(line_wr_ok), 32'd1);
        check("sw_late", 32'(late), 32'd1);
        check("sw_late_cnt", 32'(late_cnt), 32'd2);
        rd(9'd383, 12'h3C3, "sw_data");
        rd(9'd200, 12'h0C8, "stale200");

        // Two swaps without writes, then revisit the scanned bank
        swap();
        swap();
        check("two_swap_cnt", 32'(late_cnt), 32'd4);
`ifdef JTCPS1_LBUF_CLR_EN
        exp200 = 32'hFFF; exp383 = 32'hFFF;
`else
        exp200 = 32'h0C8; exp383 = 32'h3C3;
`endif
        rd(9'd200, 12'(exp200), "rescan200");
        rd(9'd383, 12'(exp383), "rescan383");

        // Saturation
        repeat (260) swap();
        check("sat_cnt", 32'(late_cnt), 32'd255);
        check("sat_late", 32'(late), 32'd1);

        // Mid-line reset
        wr_px(9'd3, 12'h0AB);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst2_wr_ok", 32'(line_wr_ok), 32'd0);
        check("rst2_cnt", 32'(late_cnt), 32'd0);
        check("rst2_pix", 32'(pix), 32'hFFF);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rel2_wr_ok", 32'(line_wr_ok), 32'd1);
        wr_px(9'd1, 12'h011);
        swap();
        check("rst2_first_late", 32'(late_cnt), 32'd1);
        rd(9'd1, 12'h011, "rst2_rd1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
